// File: rtl/mips_pkg.sv
// mips_pkg: fetch-state encoding, opcode constants and PC width shared by the fetch stage.
package mips_pkg;
    localparam int PC_W = 32;
    typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, EXEC = 2'd2} fetch_state_t;
    localparam logic [5:0] RTYPE = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04;
    localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0a, LW = 6'h23, SW = 6'h2b;
    // func field value under RTYPE
    localparam logic [5:0] JR = 6'h08;
    function automatic logic [PC_W-1:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// next_pc_sel: sequential/branch adders and the jr > jump > branch > sequential PC mux.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [25:0]     idx,
    input  logic [PC_W-1:0] rs_data,
    input  logic            branch,
    input  logic            jump,
    input  logic            jr,
    input  logic            zero,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] next_pc
);
    assign pc_plus4 = pc + 32'd4;
    always_comb
        next_pc = jr              ? rs_data & ~32'h3 :
                  jump            ? {pc_plus4[31:28], idx, 2'b00} :
                  (branch & zero) ? pc_plus4 + br_offset(idx[15:0]) :
                                    pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner, imem handshake and retire counter; FETCH_TIMEOUT_EN adds a sticky
// WAIT timeout that retries the same pc.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
)(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            Branch,
    input  logic            jump,
    input  logic            jr,
    input  logic            zero,
    input  logic [PC_W-1:0] rs_data,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic [5:0]      opc,
    output logic [5:0]      func,
    output logic            instr_valid,
    output logic [31:0]     retired,
    output logic            fetch_err
);
    fetch_state_t state;
    logic [PC_W-1:0] next_pc;
    logic drop, to_hit, accept;

    next_pc_sel u_sel (
        .pc(pc), .idx(instr[25:0]), .rs_data(rs_data), .branch(Branch), .jump(jump),
        .jr(jr), .zero(zero), .pc_plus4(pc_plus4), .next_pc(next_pc)
    );

    assign imem_addr = pc;
    assign opc = instr[31:26];
    assign func = instr[5:0];
    // rst term makes the request drop immediately rather than at the next edge
    assign imem_req = !rst && state != EXEC && !drop;
    assign instr_valid = state == EXEC;
    assign accept = imem_req && imem_ready;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wcnt;
    assign to_hit = state == WAIT && !imem_ready && wcnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wcnt <= '0;
            drop <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            wcnt <= state == WAIT ? wcnt + 8'd1 : '0;
            drop <= to_hit;
            if (to_hit) fetch_err <= 1'b1;
        end
`else
    assign to_hit = 1'b0;
    assign drop = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            instr <= '0;
            retired <= '0;
        end else if (accept) begin
            instr <= imem_rdata;
            state <= EXEC;
        end else if (to_hit) begin
            state <= REQ;
        end else if (state == REQ && !drop) begin
            state <= WAIT;
        end else if (state == EXEC && !stall) begin
            pc <= next_pc;
            retired <= retired + 32'd1;
            state <= REQ;
        end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch/branch/jump/stall/reset sequence with a fetch scoreboard.
module tb_instr_fetch_unit;
    typedef struct {logic [31:0] pc; logic [31:0] w;} exp_t;

    logic clk = 0, rst = 1;
    logic imem_req, imem_ready = 0, stall = 0, Branch = 0, jump = 0, jr = 0, zero = 0;
    logic instr_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata = 0, rs_data = 0, pc, pc_plus4, instr, retired;
    logic [5:0] opc, func;

    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    logic [31:0] exp_pc = 0, exp_ret = 0, cur_w = 0;

    localparam logic [31:0] ADDI_W = 32'h2001_0005;
    localparam logic [31:0] BEQ_W  = 32'h1022_FFFF;
    localparam logic [31:0] JR_W   = 32'h03E0_0008;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .Branch(Branch),
        .jump(jump), .jr(jr), .zero(zero), .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .opc(opc), .func(func), .instr_valid(instr_valid), .retired(retired),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in REQ; leaves it at the first EXEC negedge.
    task automatic fetch(input logic [31:0] w, input int waits);
        exp_t e;
        chk("req", imem_req, 1);
        chk("req_addr", imem_addr, exp_pc);
        chk("req_vld", instr_valid, 0);
        sb.push_back('{exp_pc, w});
        imem_rdata = w;
        imem_ready = waits == 0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_vld", instr_valid, 0);
            if (i == waits - 1) imem_ready = 1;
        end
        @(negedge clk);
        imem_ready = 0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("exec_vld", instr_valid, 1);
        chk("exec_req", imem_req, 0);
        e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_instr", instr, e.w);
        chk("opc", opc, e.w[31:26]);
        chk("func", func, e.w[5:0]);
        cur_w = w;
    endtask

    // Called at the first EXEC negedge; leaves the DUT at the next REQ negedge.
    task automatic exec(input logic br, input logic jmp, input logic jrr, input logic z,
                        input logic [31:0] rs, input int stalls, input logic [31:0] want);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        stall = 1;
        for (int i = 0; i < stalls; i++) begin
            imem_ready = 1;
            imem_rdata = ~cur_w;
            @(negedge clk);
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", instr, cur_w);
            chk("stall_ret", retired, exp_ret);
            chk("stall_vld", instr_valid, 1);
            chk("stall_req", imem_req, 0);
        end
        imem_ready = 0;
        stall = 0;
        Branch = br; jump = jmp; jr = jrr; zero = z; rs_data = rs;
        @(negedge clk);
        Branch = 0; jump = 0; jr = 0; zero = 0; rs_data = 0;
        exp_pc = want;
        exp_ret++;
        chk("next_pc", pc, exp_pc);
        chk("retired", retired, exp_ret);
        chk("post_vld", instr_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ret", retired, 32'h0);
        chk("rst_err", fetch_err, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_vld", instr_valid, 0);
        rst = 0;
        #1;
        // sequential zero-wait fetches
        fetch(ADDI_W, 0); exec(0, 0, 0, 0, 0, 0, 32'h4);
        fetch(ADDI_W, 0); exec(0, 0, 0, 0, 0, 0, 32'h8);
        fetch(ADDI_W, 0); exec(1, 0, 0, 0, 0, 0, 32'hC);
        chk("ret3", retired, 32'd3);
        fetch(32'h0800_0004, 0); exec(0, 1, 0, 0, 0, 0, 32'h10);
        // three ready-low cycles at 0x10
        fetch(ADDI_W, 3); exec(0, 0, 0, 0, 0, 0, 32'h14);
        fetch(32'h0800_0008, 0); exec(0, 1, 0, 0, 0, 0, 32'h20);
        // beq taken back to itself, then not taken
        fetch(BEQ_W, 0); exec(1, 0, 0, 1, 0, 0, 32'h20);
        fetch(BEQ_W, 0); exec(1, 0, 0, 0, 0, 0, 32'h24);
        fetch(JR_W, 0); exec(0, 0, 1, 0, 32'h4000_0000, 0, 32'h4000_0000);
        // jump beats branch, jr beats everything
        fetch(32'h0800_0100, 0); exec(1, 1, 0, 1, 0, 0, 32'h4000_0400);
        fetch(JR_W, 0); exec(1, 1, 1, 1, 32'h1237, 0, 32'h1234);
        fetch(ADDI_W, 0); exec(0, 0, 0, 0, 0, 4, 32'h1238);
        // reset in the middle of WAIT
        chk("pre_rst_req", imem_req, 1);
        imem_ready = 0;
        @(negedge clk);
        chk("mid_wait_addr", imem_addr, 32'h1238);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_ret", retired, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_vld", instr_valid, 0);
        @(negedge clk);
        rst = 0;
        #1;
        exp_pc = 0;
        exp_ret = 0;
        // 32-bit PC wrap
        fetch(JR_W, 0); exec(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC);
        fetch(ADDI_W, 0); exec(0, 0, 0, 0, 0, 0, 32'h0);
        chk("ret_after_rst", retired, 32'd2);
        chk("err_default", fetch_err, 0);
`ifdef FETCH_TIMEOUT_EN
        imem_ready = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to_wait_req", imem_req, 1);
            chk("to_wait_err", fetch_err, 0);
        end
        @(negedge clk);
        chk("to_err", fetch_err, 1);
        chk("to_drop", imem_req, 0);
        chk("to_addr", imem_addr, exp_pc);
        @(negedge clk);
        fetch(ADDI_W, 0); exec(0, 0, 0, 0, 0, 0, 32'h4);
        chk("to_sticky", fetch_err, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
